reg_file_mp: RTL and testbench

- Parametrised multi-port register file for the pipelined core.
- Provides NUM_RD combinational read ports and two write-back ports.
- Write-to-read bypass is available in the same cycle.
- A per-register pending scoreboard lets the decode stage detect RAW hazards and stall.
- Sits between decode/issue (reads, reservations) and write-back (two retire lanes).

---
 rtl/reg_file_mp.sv | 108 ++++++++++
 tb/tb_reg_file_mp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file with two write-back lanes and a RAW-hazard scoreboard.
// Define REG_FILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_mp #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_RD        = 2
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0]   RA,
    output logic [NUM_RD*DATA_WIDTH-1:0]      RD,
    output logic [NUM_RD-1:0]                 RD_VALID,
    input  logic                              WE0,
    input  logic [ADDRESS_WIDTH-1:0]          WA0,
    input  logic [DATA_WIDTH-1:0]             WD0,
    input  logic                              WE1,
    input  logic [ADDRESS_WIDTH-1:0]          WA1,
    input  logic [DATA_WIDTH-1:0]             WD1,
    input  logic                              RSV_EN,
    input  logic [ADDRESS_WIDTH-1:0]          RSV_A,
    output logic [(2**ADDRESS_WIDTH)-1:0]     PENDING,
    output logic [DATA_WIDTH-1:0]             a0
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      pending_q;
    logic [DEPTH-1:0]      pending_d;

    logic wr0_ok;
    logic wr1_ok;

    assign wr0_ok = WE0 && (WA0 != '0);
    assign wr1_ok = WE1 && (WA1 != '0);

    // Lane 1 is applied last so it overrides lane 0 on a collision.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (wr0_ok) begin
            regs_d[WA0] = WD0;
        end
        if (wr1_ok) begin
            regs_d[WA1] = WD1;
        end
    end

    // Reservation is applied after the write clears: a newer producer stays outstanding.
    always_comb begin
        pending_d = pending_q;
        if (wr0_ok) begin
            pending_d[WA0] = 1'b0;
        end
        if (wr1_ok) begin
            pending_d[WA1] = 1'b0;
        end
        if (RSV_EN && (RSV_A != '0)) begin
            pending_d[RSV_A] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
            end
            pending_q <= pending_d;
        end
    end

    assign PENDING = pending_q;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] ra;
        assign ra = RA[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
`ifdef REG_FILE_BYPASS_EN
        logic hit0;
        logic hit1;
        assign hit1 = WE1 && (WA1 == ra) && (ra != '0);
        assign hit0 = WE0 && (WA0 == ra) && (ra != '0);
        assign RD[g*DATA_WIDTH +: DATA_WIDTH] =
            hit1 ? WD1 :
            hit0 ? WD0 :
            regs_q[ra];
        assign RD_VALID[g] = !pending_q[ra] || hit0 || hit1;
`else
        assign RD[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra];
        assign RD_VALID[g] = !pending_q[ra];
`endif
    end

    if (DEPTH > 10) begin : g_a0
        localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(10);
        assign a0 = regs_q[A0_IDX];
    end else begin : g_no_a0
        assign a0 = '0;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed bench for reg_file_mp against an array/bitmask model.
// Model forwarding follows REG_FILE_BYPASS_EN as the DUT does.
module tb_reg_file_mp;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NR*AW-1:0]  RA;
    logic [NR*DW-1:0]  RD;
    logic [NR-1:0]     RD_VALID;
    logic              WE0;
    logic [AW-1:0]     WA0;
    logic [DW-1:0]     WD0;
    logic              WE1;
    logic [AW-1:0]     WA1;
    logic [DW-1:0]     WD1;
    logic              RSV_EN;
    logic [AW-1:0]     RSV_A;
    logic [DEPTH-1:0]  PENDING;
    logic [DW-1:0]     a0;

    reg_file_mp #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_RD(NR)
    ) dut (
        .CLK(CLK), .RST(RST),
        .RA(RA), .RD(RD), .RD_VALID(RD_VALID),
        .WE0(WE0), .WA0(WA0), .WD0(WD0),
        .WE1(WE1), .WA1(WA1), .WD1(WD1),
        .RSV_EN(RSV_EN), .RSV_A(RSV_A),
        .PENDING(PENDING), .a0(a0)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] pend;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (WE1 && WA1 == a) return WD1;
        if (WE0 && WA0 == a) return WD0;
`endif
        return mem[a];
    endfunction

    function automatic logic m_valid(input logic [AW-1:0] a);
        if (a == 0) return 1'b1;
`ifdef REG_FILE_BYPASS_EN
        if ((WE1 && WA1 == a) || (WE0 && WA0 == a)) return 1'b1;
`endif
        return !pend[a];
    endfunction

    task automatic idle();
        RST = 0; WE0 = 0; WE1 = 0; RSV_EN = 0;
        WA0 = 0; WA1 = 0; WD0 = 0; WD1 = 0; RSV_A = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST) begin
            for (int r = 0; r < DEPTH; r++) mem[r] = '0;
            pend = '0;
        end else begin
            if (WE0 && WA0 != 0) mem[WA0] = WD0;
            if (WE1 && WA1 != 0) mem[WA1] = WD1;
            if (WE0) pend[WA0] = 1'b0;
            if (WE1) pend[WA1] = 1'b0;
            if (RSV_EN && RSV_A != 0) pend[RSV_A] = 1'b1;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [AW-1:0] a;
        #1;
        for (int p = 0; p < NR; p++) begin
            a = RA[p*AW +: AW];
            chk({tag, "_rd"}, RD[p*DW +: DW], m_rd(a));
            chk({tag, "_valid"}, DW'(RD_VALID[p]), DW'(m_valid(a)));
        end
        chk({tag, "_pending"}, PENDING, pend);
        chk({tag, "_a0"}, a0, mem[10]);
    endtask

    initial begin
        for (int r = 0; r < DEPTH; r++) mem[r] = '0;
        pend = '0;
        idle();
        RA = '0;
        RST = 1;
        tick();
        RST = 0;

        WE0 = 1; WA0 = 5; WD0 = 32'hDEADBEEF;
        tick();
        idle();
        RST = 1;
        RA = {5'd5, 5'd5};
        tick();
        RST = 0;
        check_all("reset");
        chk("reset_rd5", RD[0 +: DW], 32'h0);
        chk("reset_pending", PENDING, 32'h0);
        chk("reset_a0", a0, 32'h0);
        chk("reset_valid", DW'(RD_VALID), 32'h3);

        WE0 = 1; WA0 = 10; WD0 = 32'h1234;
        tick();
        idle();
        RA = {5'd10, 5'd10};
        check_all("wr_a0");
        chk("wr_a0_val", a0, 32'h1234);
        chk("wr_a0_rd", RD[0 +: DW], 32'h1234);
        chk("wr_a0_valid", DW'(RD_VALID[0]), 32'h1);

        WE0 = 1; WA0 = 7; WD0 = 32'h11;
        WE1 = 1; WA1 = 7; WD1 = 32'h22;
        RA = {5'd7, 5'd7};
        check_all("coll_same");
`ifdef REG_FILE_BYPASS_EN
        chk("coll_bypass", RD[0 +: DW], 32'h22);
`endif
        tick();
        idle();
        #1;
        chk("coll_next", RD[0 +: DW], 32'h22);

        RSV_EN = 1; RSV_A = 3;
        tick();
        idle();
        RA = {5'd3, 5'd3};
        #1;
        chk("rsv_pending", DW'(PENDING[3]), 32'h1);
        chk("rsv_valid", DW'(RD_VALID[0]), 32'h0);
        WE1 = 1; WA1 = 3; WD1 = 32'h55;
        check_all("wb3");
`ifdef REG_FILE_BYPASS_EN
        chk("wb3_bypass_rd", RD[0 +: DW], 32'h55);
        chk("wb3_bypass_valid", DW'(RD_VALID[0]), 32'h1);
`else
        chk("wb3_nobypass_valid", DW'(RD_VALID[0]), 32'h0);
`endif
        tick();
        idle();
        #1;
        chk("wb3_cleared", DW'(PENDING[3]), 32'h0);

        RSV_EN = 1; RSV_A = 4;
        tick();
        RSV_EN = 1; RSV_A = 4;
        WE0 = 1; WA0 = 4; WD0 = 32'h9;
        tick();
        idle();
        RA = {5'd4, 5'd4};
        #1;
        chk("race_pending", DW'(PENDING[4]), 32'h1);
        chk("race_data", RD[0 +: DW], 32'h9);
        chk("race_valid", DW'(RD_VALID[0]), 32'h0);

        WE0 = 1; WA0 = 0; WD0 = 32'hFF;
        RSV_EN = 1; RSV_A = 0;
        RA = '0;
        check_all("x0_same");
        chk("x0_same_rd", RD[0 +: DW], 32'h0);
        tick();
        idle();
        #1;
        chk("x0_rd", RD[0 +: DW], 32'h0);
        chk("x0_pending", DW'(PENDING[0]), 32'h0);
        chk("x0_valid", DW'(RD_VALID[0]), 32'h1);

        for (int n = 0; n < 400; n++) begin
            logic narrow;
            narrow = $urandom_range(0, 1) == 1;
            RST    = ($urandom_range(0, 63) == 0);
            WE0    = $urandom_range(0, 1) == 1;
            WE1    = $urandom_range(0, 1) == 1;
            RSV_EN = $urandom_range(0, 2) != 0;
            WA0    = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            WA1    = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            RSV_A  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            WD0    = $urandom;
            WD1    = $urandom;
            RA[0 +: AW]  = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            RA[AW +: AW] = narrow ? AW'($urandom_range(0, 10)) : AW'($urandom);
            check_all("rand");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
